// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// Group sizing checks and the group generate/propagate bundle live here.
package cla_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int group_count(input int width, input int group);
    return width / group;
  endfunction

  function automatic bit cfg_ok(input int width, input int group);
    return (group > 0) && (width >= group) && (width % group == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead block: sum for a given carry-in plus the
// group generate/propagate terms used by the upper lookahead level.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] sum,
  output logic             g,
  output logic             p
);

  logic [GROUP-1:0] bg;
  logic [GROUP-1:0] bp;
  logic [GROUP-1:0] c;
  logic             acc;

  always_comb begin
    bg  = a & b;
    bp  = a ^ b;
    c   = '0;
    acc = 1'b0;
    c[0] = c_in;
    // each carry is expanded from c_in independently, not rippled
    for (int i = 1; i < GROUP; i++) begin
      c[i] = c_in;
      for (int j = 0; j < i; j++) begin
        c[i] = (c[i] & bp[j]) | bg[j];
      end
    end
    for (int j = 0; j < GROUP; j++) begin
      acc = (acc & bp[j]) | bg[j];
    end
    sum = bp ^ c;
    g   = acc;
    p   = &bp;
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined CLA adder/subtractor with valid/ready on both sides.
// Stage 1 forms group sums (carry-in 0) and G/P; stage 2 resolves carries.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = group_count(WIDTH, GROUP);

  if (!cfg_ok(WIDTH, GROUP)) begin : g_bad_cfg
    $error("WIDTH must be a non-zero multiple of GROUP");
  end

  logic             s2_advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH-1:0] sum0;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  gp_t  [NG-1:0]    gp;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_sum0;
  gp_t  [NG-1:0]    s1_gp;
  logic             s1_c0;
  logic             s1_pmsb;

  logic [NG:0]      gc;
  logic [WIDTH-1:0] nxt_sum;
  logic             nxt_cout;
  logic             nxt_ovf;
  logic             run;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(
      .GROUP(GROUP)
    ) u_grp (
      .a   (a[k*GROUP +: GROUP]),
      .b   (b_eff[k*GROUP +: GROUP]),
      .c_in(1'b0),
      .sum (sum0[k*GROUP +: GROUP]),
      .g   (grp_g[k]),
      .p   (grp_p[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NG; k++) begin
      gp[k].g = grp_g[k];
      gp[k].p = grp_p[k];
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_sum0 <= sum0;
      s1_gp   <= gp;
      s1_c0   <= c0;
      s1_pmsb <= a[WIDTH-1] ^ b_eff[WIDTH-1];
    end
  end

  always_comb begin
    gc    = '0;
    gc[0] = s1_c0;
    for (int k = 1; k <= NG; k++) begin
      gc[k] = gc[0];
      for (int j = 0; j < k; j++) begin
        gc[k] = (gc[k] & s1_gp[j].p) | s1_gp[j].g;
      end
    end
    // group carry-in of 1 increments the carry-0 group sum
    nxt_sum = '0;
    run     = 1'b0;
    for (int k = 0; k < NG; k++) begin
      run = gc[k];
      for (int i = 0; i < GROUP; i++) begin
        nxt_sum[k*GROUP+i] = s1_sum0[k*GROUP+i] ^ run;
        run = run & s1_sum0[k*GROUP+i];
      end
    end
    nxt_cout = gc[NG];
    nxt_ovf  = s1_pmsb ^ nxt_sum[WIDTH-1] ^ gc[NG];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s2_advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          sum  <= nxt_sum;
          cout <= nxt_cout;
          ovf  <= nxt_ovf;
        end
      end
    end
  end

endmodule
